// File: rtl/calc_core_param_if.sv
// calc_core_param_if: key/display bundle between keypad_driver, calc_core_param
// and segment_driver.
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   eBCD key: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear
//   disp_value signed value to display
//   err        error latched
//   busy       calculation in progress, keys are dropped
//   op_pending stored operator: 0 none, 1 add, 2 sub, 3 mul, 4 div
// master: key source / display sink.  slave: the calculator core.
interface calc_core_param_if #(
  parameter int WIDTH = 32
) ();
  logic                    key_valid;
  logic [3:0]              key_code;
  logic signed [WIDTH-1:0] disp_value;
  logic                    err;
  logic                    busy;
  logic [2:0]              op_pending;

  modport master (
    output key_valid, key_code,
    input  disp_value, err, busy, op_pending
  );

  modport slave (
    input  key_valid, key_code,
    output disp_value, err, busy, op_pending
  );
endinterface

// File: rtl/calc_core_param.sv
// calc_core_param: keypad calculator datapath. Builds signed decimal operands
// from key codes, holds a pending operator and executes chained arithmetic.
// Add/sub finish in one cycle; mul (shift-add) and div (restoring) take WIDTH
// cycles on operand magnitudes. Overflow, divide-by-zero and MIN/-1 latch err.
// Ports:
//   sw_clk  system clock
//   rst     asynchronous active-high reset
//   bus     calc_core_param_if.slave (keys in, display/status out)
// DIGITS must be small enough that 10^DIGITS-1 fits in WIDTH-1 bits.
module calc_core_param #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic              sw_clk,
  input  logic              rst,
  calc_core_param_if.slave  bus
);

  localparam int CW  = $clog2(DIGITS + 1);
  localparam int IW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [WIDTH-1:0]   ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] MIN_MAG   = {{(WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}} << 1;
  localparam logic [CW-1:0]      CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      DIG_MAX   = CW'(DIGITS);
  localparam logic [IW-1:0]      ITER_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]      ITER_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]      LAST_ITER = IW'(WIDTH - 1);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [2:0] {
    S_OPA    = 3'd0,
    S_OPB    = 3'd1,
    S_CALC   = 3'd2,
    S_RESULT = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    if (v[MSB]) mag_of = ~v + ONE;
    else        mag_of = v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
    if (neg) apply_sign = ~m + ONE;
    else     apply_sign = m;
  endfunction

  function automatic logic [2:0] key_op(input logic [3:0] k);
    case (k)
      KEY_ADD: key_op = OP_ADD;
      KEY_SUB: key_op = OP_SUB;
      KEY_MUL: key_op = OP_MUL;
      KEY_DIV: key_op = OP_DIV;
      default: key_op = OP_NONE;
    endcase
  endfunction

  // Two's complement overflow: same-sign inputs giving a different-sign result.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    add_ovf = (sa == sb) && (sr != sa);
  endfunction

  state_t               state_r, state_n;
  logic [WIDTH-1:0]     mag_r, mag_n;
  logic [CW-1:0]        cnt_r, cnt_n;
  logic                 neg_r, neg_n;
  logic [WIDTH-1:0]     opnd_r, opnd_n;
  logic [2:0]           op_r, op_n;
  logic [2:0]           calc_op_r, calc_op_n;
  logic [2:0]           next_op_r, next_op_n;
  logic [WIDTH-1:0]     a_r, a_n, b_r, b_n;
  logic                 neg_res_r, neg_res_n;
  logic                 div0_r, div0_n;
  logic [2*WIDTH-1:0]   acc_r, acc_n;
  logic [2*WIDTH-1:0]   mc_r, mc_n;
  logic [WIDTH-1:0]     sh_r, sh_n;
  logic [IW-1:0]        iter_r, iter_n;
  logic [WIDTH-1:0]     disp_r, disp_n;
  logic                 err_r, err_n;
  logic                 busy_r, busy_n;

  logic                 key_ok_s, is_digit_s, launch_s, fin_s, fin_err_s, fits_s, rem_ge_s;
  logic [2:0]           launch_op_s;
  logic [WIDTH-1:0]     buf_s, mag_dig_s, sum_s, dif_s, fin_val_s, sh_step_s;
  logic [WIDTH:0]       rem_sh_s, dvs_s, rem_nx_s;
  logic [2*WIDTH-1:0]   acc_step_s, mc_step_s, fin_mag_s;

  assign key_ok_s   = bus.key_valid && !busy_r;
  assign is_digit_s = (bus.key_code < KEY_ADD);
  assign buf_s      = apply_sign(neg_r, mag_r);
  assign mag_dig_s  = (mag_r << 3) + (mag_r << 1) + {{(WIDTH-4){1'b0}}, bus.key_code};
  assign sum_s      = a_r + b_r;
  assign dif_s      = a_r - b_r;

  // One iteration: shift-add for mul (acc=product, mc=multiplicand, sh=multiplier),
  // restoring step for div (acc=remainder, mc=divisor, sh=dividend becoming quotient).
  assign rem_sh_s   = {acc_r[WIDTH-1:0], sh_r[MSB]};
  assign dvs_s      = {1'b0, mc_r[WIDTH-1:0]};
  assign rem_ge_s   = (rem_sh_s >= dvs_s);
  assign rem_nx_s   = rem_ge_s ? (rem_sh_s - dvs_s) : rem_sh_s;
  assign acc_step_s = (calc_op_r == OP_MUL) ? (acc_r + (sh_r[0] ? mc_r : {(2*WIDTH){1'b0}}))
                                            : {{(WIDTH-1){1'b0}}, rem_nx_s};
  assign mc_step_s  = (calc_op_r == OP_MUL) ? (mc_r << 1) : mc_r;
  assign sh_step_s  = (calc_op_r == OP_MUL) ? (sh_r >> 1) : {sh_r[WIDTH-2:0], rem_ge_s};
  assign fin_mag_s  = (calc_op_r == OP_MUL) ? acc_step_s : {{WIDTH{1'b0}}, sh_step_s};
  // A negative result may reach magnitude 2^(WIDTH-1); a positive one may not.
  assign fits_s     = neg_res_r ? (fin_mag_s <= MIN_MAG) : (fin_mag_s < MIN_MAG);

  // Next-state and datapath decode: key handling, calculation steps, completion.
  always_comb begin
    state_n = state_r;  mag_n = mag_r;  cnt_n = cnt_r;  neg_n = neg_r;
    opnd_n = opnd_r;  op_n = op_r;  calc_op_n = calc_op_r;  next_op_n = next_op_r;
    a_n = a_r;  b_n = b_r;  neg_res_n = neg_res_r;  div0_n = div0_r;
    acc_n = acc_r;  mc_n = mc_r;  sh_n = sh_r;  iter_n = iter_r;
    disp_n = disp_r;  err_n = err_r;  busy_n = busy_r;
    launch_s = 1'b0;  launch_op_s = OP_NONE;
    fin_s = 1'b0;  fin_err_s = 1'b0;  fin_val_s = ZERO;

    if (key_ok_s && (bus.key_code == KEY_CLR)) begin
      state_n = S_OPA;  mag_n = ZERO;  cnt_n = CNT_ZERO;  neg_n = 1'b0;
      opnd_n = ZERO;  op_n = OP_NONE;  disp_n = ZERO;  err_n = 1'b0;  busy_n = 1'b0;
    end else if (state_r == S_CALC) begin
      if (calc_op_r == OP_ADD) begin
        fin_s = 1'b1;  fin_val_s = sum_s;
        fin_err_s = add_ovf(a_r[MSB], b_r[MSB], sum_s[MSB]);
      end else if (calc_op_r == OP_SUB) begin
        fin_s = 1'b1;  fin_val_s = dif_s;
        fin_err_s = add_ovf(a_r[MSB], ~b_r[MSB], dif_s[MSB]);
      end else if (iter_r == LAST_ITER) begin
        fin_s = 1'b1;
        fin_val_s = apply_sign(neg_res_r, fin_mag_s[WIDTH-1:0]);
        fin_err_s = !fits_s || ((calc_op_r == OP_DIV) && div0_r);
      end else begin
        acc_n = acc_step_s;  mc_n = mc_step_s;  sh_n = sh_step_s;  iter_n = iter_r + ITER_ONE;
      end
    end else if (key_ok_s && (state_r != S_ERR)) begin
      if (is_digit_s) begin
        if (state_r == S_RESULT) begin
          state_n = S_OPA;  neg_n = 1'b0;  cnt_n = CNT_ONE;
          mag_n = {{(WIDTH-4){1'b0}}, bus.key_code};
          disp_n = {{(WIDTH-4){1'b0}}, bus.key_code};
        end else if (cnt_r < DIG_MAX) begin
          mag_n = mag_dig_s;  cnt_n = cnt_r + CNT_ONE;  disp_n = apply_sign(neg_r, mag_dig_s);
        end else begin
          mag_n = mag_r;
        end
      end else if (bus.key_code == KEY_EQ) begin
        if (state_r == S_OPA) begin
          state_n = S_RESULT;  disp_n = buf_s;  opnd_n = buf_s;
          mag_n = ZERO;  cnt_n = CNT_ZERO;  neg_n = 1'b0;
        end else if ((state_r == S_OPB) && (cnt_r != CNT_ZERO)) begin
          launch_s = 1'b1;  launch_op_s = OP_NONE;
        end else begin
          state_n = state_r;
        end
      end else begin
        // '-' before any digit is the entry sign, not an operator.
        if ((bus.key_code == KEY_SUB) && (cnt_r == CNT_ZERO) && (state_r != S_RESULT)) begin
          neg_n = ~neg_r;
        end else if (state_r == S_OPA) begin
          state_n = S_OPB;  opnd_n = buf_s;  disp_n = buf_s;  op_n = key_op(bus.key_code);
          mag_n = ZERO;  cnt_n = CNT_ZERO;  neg_n = 1'b0;
        end else if ((state_r == S_RESULT) || (cnt_r == CNT_ZERO)) begin
          state_n = S_OPB;  op_n = key_op(bus.key_code);
        end else begin
          launch_s = 1'b1;  launch_op_s = key_op(bus.key_code);
        end
      end
    end else begin
      state_n = state_r;
    end

    if (launch_s) begin
      state_n = S_CALC;  busy_n = 1'b1;  iter_n = ITER_ZERO;
      a_n = opnd_r;  b_n = buf_s;  calc_op_n = op_r;  next_op_n = launch_op_s;
      neg_res_n = opnd_r[MSB] ^ buf_s[MSB];
      div0_n = (buf_s == ZERO);
      acc_n = {(2*WIDTH){1'b0}};
      if (op_r == OP_MUL) begin
        mc_n = {{WIDTH{1'b0}}, mag_of(opnd_r)};  sh_n = mag_of(buf_s);
      end else begin
        mc_n = {{WIDTH{1'b0}}, mag_of(buf_s)};   sh_n = mag_of(opnd_r);
      end
      mag_n = ZERO;  cnt_n = CNT_ZERO;  neg_n = 1'b0;
    end else if (fin_s) begin
      busy_n = 1'b0;
      if (fin_err_s) begin
        state_n = S_ERR;  err_n = 1'b1;  disp_n = ZERO;  op_n = OP_NONE;
      end else begin
        opnd_n = fin_val_s;  disp_n = fin_val_s;  op_n = next_op_r;
        state_n = (next_op_r == OP_NONE) ? S_RESULT : S_OPB;
      end
    end else begin
      busy_n = busy_n;
    end
  end

  // State and datapath registers; rst clears everything asynchronously.
  always_ff @(posedge sw_clk or posedge rst) begin
    if (rst) begin
      state_r <= S_OPA;  mag_r <= ZERO;  cnt_r <= CNT_ZERO;  neg_r <= 1'b0;
      opnd_r <= ZERO;  op_r <= OP_NONE;  calc_op_r <= OP_NONE;  next_op_r <= OP_NONE;
      a_r <= ZERO;  b_r <= ZERO;  neg_res_r <= 1'b0;  div0_r <= 1'b0;
      acc_r <= {(2*WIDTH){1'b0}};  mc_r <= {(2*WIDTH){1'b0}};  sh_r <= ZERO;
      iter_r <= ITER_ZERO;  disp_r <= ZERO;  err_r <= 1'b0;  busy_r <= 1'b0;
    end else begin
      state_r <= state_n;  mag_r <= mag_n;  cnt_r <= cnt_n;  neg_r <= neg_n;
      opnd_r <= opnd_n;  op_r <= op_n;  calc_op_r <= calc_op_n;  next_op_r <= next_op_n;
      a_r <= a_n;  b_r <= b_n;  neg_res_r <= neg_res_n;  div0_r <= div0_n;
      acc_r <= acc_n;  mc_r <= mc_n;  sh_r <= sh_n;
      iter_r <= iter_n;  disp_r <= disp_n;  err_r <= err_n;  busy_r <= busy_n;
    end
  end

  assign bus.disp_value = disp_r;
  assign bus.err        = err_r;
  assign bus.busy       = busy_r;
  assign bus.op_pending = op_r;

endmodule

// File: tb/tb_calc_core_param.sv
// tb_calc_core_param: directed scenarios with constant expectations, then a
// randomized key stream checked against a behavioural calculator model that
// works on plain 64-bit integers.
module tb_calc_core_param;
  localparam int W = 32;
  localparam int DIGITS = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  calc_core_param_if #(.WIDTH(W)) bus ();

  calc_core_param #(.WIDTH(W), .DIGITS(DIGITS)) dut (
    .sw_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int     m_state;   // 0 entering A, 1 entering B, 2 result, 3 error
  longint m_mag, m_opnd, m_disp;
  int     m_cnt, m_op;
  bit     m_neg, m_err;

  function automatic longint m_buf();
    return m_neg ? -m_mag : m_mag;
  endfunction

  task automatic m_clear_entry();
    m_mag = 0; m_cnt = 0; m_neg = 1'b0;
  endtask

  task automatic m_clear();
    m_clear_entry(); m_state = 0; m_opnd = 0; m_op = 0; m_disp = 0; m_err = 1'b0;
  endtask

  task automatic m_compute(input int nop, output int lat);
    longint a, b, r;
    bit bad;
    a = m_opnd; b = m_buf(); bad = 1'b0; r = 0;
    lat = (m_op >= 3) ? W : 1;
    case (m_op)
      1: r = a + b;
      2: r = a - b;
      3: r = a * b;
      default: if (b == 0) bad = 1'b1; else r = a / b;
    endcase
    if (r > MAXV || r < MINV) bad = 1'b1;
    m_clear_entry();
    if (bad) begin
      m_state = 3; m_err = 1'b1; m_disp = 0; m_op = 0;
    end else begin
      m_opnd = r; m_disp = r; m_op = nop; m_state = (nop == 0) ? 2 : 1;
    end
  endtask

  task automatic m_key(input int k, output int lat);
    lat = 0;
    if (k == 15) m_clear();
    else if (m_state == 3) lat = 0;
    else if (k < 10) begin
      if (m_state == 2) begin
        m_clear_entry(); m_state = 0; m_mag = k; m_cnt = 1; m_disp = k;
      end else if (m_cnt < DIGITS) begin
        m_mag = m_mag * 10 + k; m_cnt++; m_disp = m_buf();
      end
    end else if (k == 14) begin
      if (m_state == 0) begin
        m_disp = m_buf(); m_opnd = m_buf(); m_state = 2; m_clear_entry();
      end else if (m_state == 1 && m_cnt > 0) m_compute(0, lat);
    end else begin
      if (k == 11 && m_cnt == 0 && m_state != 2) m_neg = !m_neg;
      else if (m_state == 0) begin
        m_opnd = m_buf(); m_disp = m_buf(); m_op = k - 9; m_clear_entry(); m_state = 1;
      end else if (m_state == 2 || m_cnt == 0) begin
        m_op = k - 9; m_state = 1;
      end else m_compute(k - 9, lat);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Press one key; returns the number of cycles busy stayed high (-1 on timeout).
  // With poke set, a digit 5 is pulsed while busy.
  task automatic press(input logic [3:0] code, input bit poke, output int cyc);
    @(negedge clk); bus.key_valid = 1'b1; bus.key_code = code;
    @(posedge clk); #1; bus.key_valid = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (poke && cyc == 3) begin
        @(negedge clk); bus.key_valid = 1'b1; bus.key_code = 4'd5;
        @(posedge clk); #1; bus.key_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (cyc >= 200) cyc = -1;
  endtask

  function automatic logic [3:0] char_code(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
    case (c)
      8'h2B:   return 4'd10;  // +
      8'h2D:   return 4'd11;  // -
      8'h2A:   return 4'd12;  // *
      8'h2F:   return 4'd13;  // /
      8'h3D:   return 4'd14;  // =
      default: return 4'd15;  // C
    endcase
  endfunction

  task automatic type_keys(input string s, output int last_cyc);
    int cyc;
    last_cyc = 0;
    for (int i = 0; i < s.len(); i++) begin
      press(char_code(s[i]), 1'b0, cyc);
      last_cyc = cyc;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; bus.key_valid = 1'b0; bus.key_code = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.disp_value !== 32'sd0) $display("FAIL reset_disp: got %0d want 0", bus.disp_value); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.op_pending !== 3'd0) $display("FAIL reset_op: got %0d want 0", bus.op_pending); else n_pass++;
  endtask

  task automatic test_add();
    int cyc;
    type_keys("C12+34=", cyc);
    n_total++; if (cyc !== 1) $display("FAIL add_busy: got %0d want 1", cyc); else n_pass++;
    n_total++; if (bus.disp_value !== 32'sd46) $display("FAIL add_disp: got %0d want 46", bus.disp_value); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL add_err: got %b want 0", bus.err); else n_pass++;
  endtask

  task automatic test_mul();
    int cyc;
    type_keys("C-7*6", cyc);
    n_total++; if (bus.op_pending !== 3'd3) $display("FAIL mul_op: got %0d want 3", bus.op_pending); else n_pass++;
    press(4'd14, 1'b1, cyc);
    n_total++; if (cyc !== 32) $display("FAIL mul_busy: got %0d want 32", cyc); else n_pass++;
    n_total++; if (bus.disp_value !== -32'sd42) $display("FAIL mul_disp: got %0d want -42", bus.disp_value); else n_pass++;
    n_total++; if (bus.op_pending !== 3'd0) $display("FAIL mul_op_done: got %0d want 0", bus.op_pending); else n_pass++;
  endtask

  task automatic test_div_zero();
    int cyc;
    type_keys("C9/0=", cyc);
    n_total++; if (cyc !== 32) $display("FAIL div0_busy: got %0d want 32", cyc); else n_pass++;
    n_total++; if (bus.err !== 1'b1) $display("FAIL div0_err: got %b want 1", bus.err); else n_pass++;
    n_total++; if (bus.disp_value !== 32'sd0) $display("FAIL div0_disp: got %0d want 0", bus.disp_value); else n_pass++;
    type_keys("9", cyc);
    n_total++; if (bus.err !== 1'b1 || bus.disp_value !== 32'sd0)
      $display("FAIL err_hold: got err=%b disp=%0d want err=1 disp=0", bus.err, bus.disp_value); else n_pass++;
    type_keys("C", cyc);
    n_total++; if (bus.err !== 1'b0 || bus.disp_value !== 32'sd0)
      $display("FAIL err_clear: got err=%b disp=%0d want err=0 disp=0", bus.err, bus.disp_value); else n_pass++;
  endtask

  task automatic test_digits();
    int cyc;
    type_keys("C123456789", cyc);
    n_total++; if (bus.disp_value !== 32'sd12345678) $display("FAIL digit_limit: got %0d want 12345678", bus.disp_value); else n_pass++;
    type_keys("-1=", cyc);
    n_total++; if (bus.disp_value !== 32'sd12345677) $display("FAIL digit_sub: got %0d want 12345677", bus.disp_value); else n_pass++;
  endtask

  task automatic test_chain();
    int cyc;
    type_keys("C5+3*", cyc);
    n_total++; if (cyc !== 1) $display("FAIL chain_busy: got %0d want 1", cyc); else n_pass++;
    n_total++; if (bus.disp_value !== 32'sd8 || bus.op_pending !== 3'd3)
      $display("FAIL chain_mid: got disp=%0d op=%0d want disp=8 op=3", bus.disp_value, bus.op_pending); else n_pass++;
    type_keys("2=", cyc);
    n_total++; if (bus.disp_value !== 32'sd16) $display("FAIL chain_end: got %0d want 16", bus.disp_value); else n_pass++;
    type_keys("C-7/2=", cyc);
    n_total++; if (bus.disp_value !== -32'sd3) $display("FAIL div_trunc: got %0d want -3", bus.disp_value); else n_pass++;
  endtask

  task automatic test_overflow();
    int cyc;
    type_keys("C99999999*99=", cyc);
    n_total++; if (bus.err !== 1'b1 || bus.disp_value !== 32'sd0)
      $display("FAIL mul_ovf: got err=%b disp=%0d want err=1 disp=0", bus.err, bus.disp_value); else n_pass++;
    type_keys("C99999999*21+", cyc);
    n_total++; if (bus.disp_value !== 32'sd2099999979) $display("FAIL mul_big: got %0d want 2099999979", bus.disp_value); else n_pass++;
    type_keys("99999999=", cyc);
    n_total++; if (bus.err !== 1'b1) $display("FAIL add_ovf: got err=%b want 1", bus.err); else n_pass++;
    type_keys("C-65536*32768/", cyc);
    n_total++; if (bus.err !== 1'b0 || bus.disp_value !== -32'sd2147483648)
      $display("FAIL mul_min: got err=%b disp=%0d want err=0 disp=-2147483648", bus.err, bus.disp_value); else n_pass++;
    type_keys("-1=", cyc);
    n_total++; if (bus.err !== 1'b1) $display("FAIL min_div_neg1: got err=%b want 1", bus.err); else n_pass++;
  endtask

  task automatic test_rst_mid();
    int cyc;
    type_keys("C100/7", cyc);
    @(negedge clk); bus.key_valid = 1'b1; bus.key_code = 4'd14;
    @(posedge clk); #1; bus.key_valid = 1'b0;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", bus.busy); else n_pass++;
    repeat (5) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    n_total++; if (bus.busy !== 1'b0 || bus.disp_value !== 32'sd0 || bus.op_pending !== 3'd0)
      $display("FAIL rst_async: got busy=%b disp=%0d op=%0d want 0 0 0", bus.busy, bus.disp_value, bus.op_pending); else n_pass++;
    @(negedge clk); rst = 1'b0;
    type_keys("12+34=", cyc);
    n_total++; if (bus.disp_value !== 32'sd46) $display("FAIL rst_recover: got %0d want 46", bus.disp_value); else n_pass++;
  endtask

  task automatic test_random();
    int cyc, lat, r, k;
    bit poke;
    logic signed [31:0] exp_disp;
    m_clear();
    press(4'd15, 1'b0, cyc);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 85) k = $urandom_range(10, 13);
      else if (r < 96) k = 14;
      else             k = 15;
      poke = ($urandom_range(0, 3) == 0);
      m_key(k, lat);
      press(4'(k), poke, cyc);
      exp_disp = 32'(m_disp);
      n_total++; if (cyc !== lat) $display("FAIL rnd_busy[%0d] key %0d: got %0d want %0d", i, k, cyc, lat); else n_pass++;
      n_total++; if (bus.disp_value !== exp_disp) $display("FAIL rnd_disp[%0d] key %0d: got %0d want %0d", i, k, bus.disp_value, exp_disp); else n_pass++;
      n_total++; if (bus.err !== m_err) $display("FAIL rnd_err[%0d] key %0d: got %b want %b", i, k, bus.err, m_err); else n_pass++;
      n_total++; if (bus.op_pending !== 3'(m_op)) $display("FAIL rnd_op[%0d] key %0d: got %0d want %0d", i, k, bus.op_pending, m_op); else n_pass++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_add();
    test_mul();
    test_div_zero();
    test_digits();
    test_chain();
    test_overflow();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
- Parametrised successor to the keypad calculator datapath: it sequences eBCD key codes into operands, holds a pending operator, and executes chained arithmetic.
- Add and subtract are single-cycle; multiply and divide are iterative.
- Detects overflow and divide-by-zero, then latches an error.
- Sits between keypad_driver (one key pulse per press) and segment_driver (value to display).

Parameters:
- WIDTH, 32, signed operand/result width in bits (minimum 8).
- DIGITS, 8, maximum decimal digits accepted per operand entry.

Ports:
- sw_clk  input  1  system clock for the block.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle strobe; key_code is valid.
- key_code  input  4  eBCD code: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear.
- disp_value  output  WIDTH  signed value to display.
- err  output  1  error latched.
- busy  output  1  calculation in progress; keys are ignored.
- op_pending  output  3  stored operator: 0 none, 1 add, 2 sub, 3 mul, 4 div.

Behaviour:
- Reset (asynchronous, any state, including mid-calculation):
  - State goes to S_OPA; buffer, operands, digit count and sign are cleared.
  - disp_value=0, err=0, busy=0, op_pending=0.
- States: S_OPA, S_OPB, S_CALC, S_RESULT, S_ERR.
- Keys are accepted only on a sw_clk edge with key_valid=1 and busy=0. In S_CALC, keys are dropped, not queued.
- Digit entry (S_OPA/S_OPB):
  - If digit count < DIGITS: magnitude = magnitude*10 + d and count increments.
  - Otherwise the digit is ignored.
  - disp_value shows the signed buffer on the next cycle.
- '-' with digit count 0 in S_OPA/S_OPB toggles the entry sign; the display is unchanged until a digit arrives.
- Operator in S_OPA: operand0 = signed buffer; store operator; clear buffer; go to S_OPB. disp_value keeps operand0.
- Operator in S_OPB with count 0 (except the '-' sign rule): replaces the stored operator only.
- Operator in S_OPB with count > 0:
  - Compute operand0 op buffer.
  - On completion: result goes to operand0, the new operator is stored, and the state returns to S_OPB.
- '=' in S_OPB with count > 0: compute, then go to S_RESULT.
- '=' in S_OPA: disp_value = buffer; go to S_RESULT.
- '=' in S_OPB with count 0: ignored.
- S_RESULT:
  - A digit starts a fresh S_OPA entry.
  - An operator uses the result as operand0 and goes to S_OPB.
  - '=' is ignored.
- S_CALC latency (busy high for exactly this many cycles after the accepting edge):
  - add/sub: 1 cycle.
  - mul: WIDTH cycles, shift-add on magnitudes with a 2*WIDTH-bit product.
  - div: WIDTH cycles, restoring division on magnitudes; quotient truncates toward zero; remainder is discarded.
  - disp_value, op_pending and err update on the same edge that busy falls.
- Errors (enter S_ERR, err=1, disp_value=0):
  - add/sub signed overflow (operand signs equal, result sign differs).
  - Product magnitude outside the signed WIDTH range. -(2^(WIDTH-1)) is legal.
  - Divisor 0.
  - MIN / -1.
- S_ERR: every key except clear is ignored.
- Clear (code 15), any state except S_CALC: same effect as reset, synchronous, on the next edge.
- Entering S_CALC with no operator stored is impossible by construction.

Test Plan:
- Keys 1,2,+,3,4,= → busy high for 1 cycle; disp_value=46, err=0, state S_RESULT.
- Keys -,7,*,6,= → busy high for exactly 32 cycles; disp_value=-42. Key 5 pulsed during busy is ignored.
- Keys 9,/,0,= → err=1, disp_value=0 after 32 busy cycles. Key 9 is ignored; clear gives err=0, disp_value=0.
- Keys 1,2,3,4,5,6,7,8,9 → disp_value=12345678 (ninth digit dropped). Then -,1,= → 12345677.
- Chaining keys 5,+,3,*,2,= → disp_value=8 after '*' is accepted, then 16 after '='.
  - Also: -,7,/,2,= → -3.
- Keys 9,9,9,9,9,9,9,9,*,9,9,= → err=1 (9899999901 > 2^31-1).
  - Separately: rst asserted mid-divide → busy=0, disp_value=0, op_pending=0 immediately, without waiting for a clock edge.
